// File: rtl/ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
// The 2-bit state encodings and NOP word are also used by if_id and id_ex.
package ctrl_pkg;

   localparam logic [1:0]  CTRL_IDLE  = 2'd0;
   localparam logic [1:0]  CTRL_PEND  = 2'd1;
   localparam logic [1:0]  CTRL_FLUSH = 2'd2;
   localparam logic [31:0] INST_NOP   = 32'h0000_0013;

   typedef enum logic [1:0] {
      StIdle  = CTRL_IDLE,
      StPend  = CTRL_PEND,
      StFlush = CTRL_FLUSH
   } ctrl_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/ctrl_if.sv
// Redirect/stall request bundle from execute and bus, plus the control outputs.
// The slave modport is the control unit; master is the requesting side.
interface ctrl_if;

   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_ex_i;
   logic        hold_flag_bus_i;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        flush_o;
   logic        hold_pc_o;
   logic        hold_if_id_o;
   logic        hold_id_ex_o;
   logic [31:0] stall_cnt_o;

   modport slave (
      input  jump_en_i, jump_addr_i, hold_flag_ex_i, hold_flag_bus_i,
      output jump_en_o, jump_addr_o, flush_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
      output stall_cnt_o
   );

   modport master (
      output jump_en_i, jump_addr_i, hold_flag_ex_i, hold_flag_bus_i,
      input  jump_en_o, jump_addr_o, flush_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
      input  stall_cnt_o
   );

endinterface

// File: rtl/ctrl.sv
// Pipeline control: PC redirect, if_id/id_ex flush, stage hold and stall counting.
// A redirect that meets a hold is parked in PEND and issued when the hold drops.
module ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic  clk,
   input  logic  rst,
   ctrl_if.slave ctrl_io
);

   localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

   ctrl_state_e state_q, state_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic        hold_any;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        flush;

   assign hold_any = ctrl_io.hold_flag_ex_i | ctrl_io.hold_flag_bus_i;

   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      flush_cnt_d = flush_cnt_q;
      jump_en     = 1'b0;
      jump_addr   = 32'd0;
      flush       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (ctrl_io.jump_en_i) begin
               if (hold_any) begin
                  pend_addr_d = ctrl_io.jump_addr_i;
                  state_d     = StPend;
               end else begin
                  jump_en   = 1'b1;
                  jump_addr = ctrl_io.jump_addr_i;
                  flush     = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d     = StFlush;
                     flush_cnt_d = FlushInit;
                  end
               end
            end
         end
         StPend: begin
            if (!hold_any) begin
               jump_en   = 1'b1;
               jump_addr = pend_addr_q;
               flush     = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = StFlush;
                  flush_cnt_d = FlushInit;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StFlush: begin
            // New jumps here come from squashed instructions and are dropped.
            flush = 1'b1;
            if (!hold_any) begin
               flush_cnt_d = flush_cnt_q - 3'd1;
               if (flush_cnt_q == 3'd1) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign stall_cnt_d = hold_any ? sat_inc(stall_cnt_q) : stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pend_addr_q <= 32'd0;
         flush_cnt_q <= 3'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ctrl_io.jump_en_o    = jump_en & ~rst;
   assign ctrl_io.jump_addr_o  = rst ? 32'd0 : jump_addr;
   assign ctrl_io.flush_o      = flush & ~rst;
   assign ctrl_io.hold_pc_o    = hold_any & ~rst;
   assign ctrl_io.hold_if_id_o = hold_any & ~rst;
   assign ctrl_io.hold_id_ex_o = hold_any & ~rst;
   assign ctrl_io.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_ctrl.sv
// Bench for ctrl: directed vector table, hand sequences and a random run
// against a cycle-level behavioural model, for FLUSH_CYCLES of 2 and 1.
module tb_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ctrl_if if2 ();
   ctrl_if if1 ();

   ctrl #(.FLUSH_CYCLES(2)) u_ctrl2 (.clk(clk), .rst(rst), .ctrl_io(if2.slave));
   ctrl #(.FLUSH_CYCLES(1)) u_ctrl1 (.clk(clk), .rst(rst), .ctrl_io(if1.slave));

   typedef struct {
      logic        jin;
      logic [31:0] ain;
      logic        hex;
      logic        hbus;
      logic        ej;
      logic [31:0] ea;
      logic        ef;
      logic        eh;
      logic [31:0] es;
   } vec_t;

   typedef struct {
      bit          pend;
      logic [31:0] paddr;
      int          left;
      logic [31:0] cnt;
   } mdl_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic jin, input logic [31:0] ain, input logic hex,
                        input logic hbus);
      if2.jump_en_i = jin; if2.jump_addr_i = ain;
      if2.hold_flag_ex_i = hex; if2.hold_flag_bus_i = hbus;
      if1.jump_en_i = jin; if1.jump_addr_i = ain;
      if1.hold_flag_ex_i = hex; if1.hold_flag_bus_i = hbus;
   endtask

   function automatic vec_t mk(input logic jin, input logic [31:0] ain, input logic hex,
                               input logic hbus, input logic ej, input logic [31:0] ea,
                               input logic ef, input logic eh, input logic [31:0] es);
      vec_t v;
      v.jin = jin; v.ain = ain; v.hex = hex; v.hbus = hbus;
      v.ej = ej; v.ea = ea; v.ef = ef; v.eh = eh; v.es = es;
      return v;
   endfunction

   // Spec-level model: one pending slot, remaining flush count, saturating stall count.
   task automatic model_step(input int fc, input mdl_t mi, input logic jin,
                             input logic [31:0] ain, input logic hold, output mdl_t mo,
                             output logic ej, output logic [31:0] ea, output logic ef);
      mo = mi; ej = 1'b0; ea = 32'd0; ef = 1'b0;
      if (mi.left > 0) begin
         ef = 1'b1;
         if (!hold) mo.left = mi.left - 1;
      end else if (mi.pend) begin
         if (!hold) begin
            ej = 1'b1; ea = mi.paddr; ef = 1'b1; mo.pend = 1'b0; mo.left = fc - 1;
         end
      end else if (jin) begin
         if (hold) begin
            mo.pend = 1'b1; mo.paddr = ain;
         end else begin
            ej = 1'b1; ea = ain; ef = 1'b1; mo.left = fc - 1;
         end
      end
      if (hold && mi.cnt != 32'hFFFF_FFFF) mo.cnt = mi.cnt + 32'd1;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      mdl_t        m1, m2, n1, n2;
      logic        ej, ef;
      logic [31:0] ea;
      logic        jin, hex, hbus;
      logic [31:0] ain;

      //            jin ain           hex  hbus ej  ea            ef  eh  es
      tbl[0]  = mk(0, 32'h0,        0, 0, 0, 32'h0,   0, 0, 0);
      tbl[1]  = mk(1, 32'h100,      0, 0, 1, 32'h100, 1, 0, 0);
      tbl[2]  = mk(0, 32'h0,        0, 0, 0, 32'h0,   1, 0, 0);
      tbl[3]  = mk(0, 32'h0,        0, 0, 0, 32'h0,   0, 0, 0);
      tbl[4]  = mk(1, 32'h40,       0, 1, 0, 32'h0,   0, 1, 0);
      tbl[5]  = mk(0, 32'h0,        0, 1, 0, 32'h0,   0, 1, 1);
      tbl[6]  = mk(0, 32'h0,        0, 1, 0, 32'h0,   0, 1, 2);
      tbl[7]  = mk(0, 32'h0,        0, 0, 1, 32'h40,  1, 0, 3);
      tbl[8]  = mk(0, 32'h0,        0, 0, 0, 32'h0,   1, 0, 3);
      tbl[9]  = mk(0, 32'h0,        0, 0, 0, 32'h0,   0, 0, 3);
      tbl[10] = mk(1, 32'h200,      0, 0, 1, 32'h200, 1, 0, 3);
      tbl[11] = mk(1, 32'h999,      1, 0, 0, 32'h0,   1, 1, 3);
      tbl[12] = mk(0, 32'h0,        1, 0, 0, 32'h0,   1, 1, 4);
      tbl[13] = mk(1, 32'h55,       0, 0, 0, 32'h0,   1, 0, 5);
      tbl[14] = mk(0, 32'h0,        0, 0, 0, 32'h0,   0, 0, 5);
      tbl[15] = mk(1, 32'h300,      1, 1, 0, 32'h0,   0, 1, 5);
      tbl[16] = mk(1, 32'h444,      0, 1, 0, 32'h0,   0, 1, 6);
      tbl[17] = mk(0, 32'h0,        0, 0, 1, 32'h300, 1, 0, 7);
      tbl[18] = mk(0, 32'h0,        0, 0, 0, 32'h0,   1, 0, 7);
      tbl[19] = mk(0, 32'h0,        0, 0, 0, 32'h0,   0, 0, 7);

      do_reset();
      @(negedge clk);
      chk("reset_stall", if2.stall_cnt_o, 32'd0);
      chk("reset_flush", {31'd0, if2.flush_o}, 32'd0);

      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 drive(tbl[i].jin, tbl[i].ain, tbl[i].hex, tbl[i].hbus);
         @(negedge clk);
         chk($sformatf("vec%0d_jump_en", i), {31'd0, if2.jump_en_o}, {31'd0, tbl[i].ej});
         chk($sformatf("vec%0d_jump_addr", i), if2.jump_addr_o, tbl[i].ea);
         chk($sformatf("vec%0d_flush", i), {31'd0, if2.flush_o}, {31'd0, tbl[i].ef});
         chk($sformatf("vec%0d_hold", i),
             {29'd0, if2.hold_pc_o, if2.hold_if_id_o, if2.hold_id_ex_o}, {29'd0, {3{tbl[i].eh}}});
         chk($sformatf("vec%0d_stall", i), if2.stall_cnt_o, tbl[i].es);
      end

      // Reset in the middle of PEND.
      @(posedge clk);
      #1 drive(1'b1, 32'h80, 1'b0, 1'b1);
      @(negedge clk);
      chk("pend_entry_jump_en", {31'd0, if2.jump_en_o}, 32'd0);
      @(posedge clk);
      #1 drive(1'b0, 32'h0, 1'b0, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rst_jump_en", {31'd0, if2.jump_en_o}, 32'd0);
      chk("rst_jump_addr", if2.jump_addr_o, 32'd0);
      chk("rst_flush", {31'd0, if2.flush_o}, 32'd0);
      chk("rst_hold", {29'd0, if2.hold_pc_o, if2.hold_if_id_o, if2.hold_id_ex_o}, 32'd0);
      chk("rst_stall", if2.stall_cnt_o, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_jump_en", i), {31'd0, if2.jump_en_o}, 32'd0);
         chk($sformatf("post_rst%0d_flush", i), {31'd0, if2.flush_o}, 32'd0);
         chk($sformatf("post_rst%0d_stall", i), if2.stall_cnt_o, 32'd0);
      end

      // Stall counter saturation.
      @(posedge clk);
      #1 force u_ctrl2.stall_cnt_q = 32'hFFFF_FFFE;
      #1 release u_ctrl2.stall_cnt_q;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d", i), if2.stall_cnt_o, 32'hFFFF_FFFF);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("sat_hold_released", if2.stall_cnt_o, 32'hFFFF_FFFF);

      // FLUSH_CYCLES=1: back-to-back redirects both issue.
      @(posedge clk);
      #1 drive(1'b1, 32'h10, 1'b0, 1'b0);
      @(negedge clk);
      chk("fc1_a_jump_en", {31'd0, if1.jump_en_o}, 32'd1);
      chk("fc1_a_jump_addr", if1.jump_addr_o, 32'h10);
      chk("fc1_a_flush", {31'd0, if1.flush_o}, 32'd1);
      @(posedge clk);
      #1 drive(1'b1, 32'h20, 1'b0, 1'b0);
      @(negedge clk);
      chk("fc1_b_jump_en", {31'd0, if1.jump_en_o}, 32'd1);
      chk("fc1_b_jump_addr", if1.jump_addr_o, 32'h20);
      chk("fc2_b_squashed", {31'd0, if2.jump_en_o}, 32'd0);
      @(posedge clk);
      #1 drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("fc1_c_flush", {31'd0, if1.flush_o}, 32'd0);
      chk("fc1_c_jump_en", {31'd0, if1.jump_en_o}, 32'd0);

      // Random run against the model for both instances.
      do_reset();
      m1 = '{pend: 1'b0, paddr: 32'd0, left: 0, cnt: 32'd0};
      m2 = m1;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         jin  = ($urandom_range(2) == 0);
         hex  = ($urandom_range(3) == 0);
         hbus = ($urandom_range(3) == 0);
         ain  = $urandom;
         #1 drive(jin, ain, hex, hbus);
         @(negedge clk);
         model_step(2, m2, jin, ain, hex | hbus, n2, ej, ea, ef);
         chk("rnd2_jump_en", {31'd0, if2.jump_en_o}, {31'd0, ej});
         chk("rnd2_jump_addr", if2.jump_addr_o, ea);
         chk("rnd2_flush", {31'd0, if2.flush_o}, {31'd0, ef});
         chk("rnd2_hold", {31'd0, if2.hold_id_ex_o}, {31'd0, hex | hbus});
         chk("rnd2_stall", if2.stall_cnt_o, m2.cnt);
         model_step(1, m1, jin, ain, hex | hbus, n1, ej, ea, ef);
         chk("rnd1_jump_en", {31'd0, if1.jump_en_o}, {31'd0, ej});
         chk("rnd1_jump_addr", if1.jump_addr_o, ea);
         chk("rnd1_flush", {31'd0, if1.flush_o}, {31'd0, ef});
         chk("rnd1_hold", {31'd0, if1.hold_pc_o}, {31'd0, hex | hbus});
         chk("rnd1_stall", if1.stall_cnt_o, m1.cnt);
         m1 = n1;
         m2 = n2;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
